// File: rtl/video_data_decoder.sv
// rtl/video_data_decoder.sv - BT.656 receiver: SAV/EAV lock, luma slicing into bytes, FWFT output FIFO
// Optional: VIDEO_DATA_DECODER_PROT_CHECK_EN enables XY protection checking and xy_errors counting.
module video_data_decoder #(
    parameter logic [7:0] THRESHOLD  = 8'h80,
    parameter int         SKIP_Y     = 8,
    parameter int         FIFO_DEPTH = 16
) (
    input  logic       TD_CLK27,
    input  logic       rst,
    input  logic [7:0] TD_DATA,
    input  logic       enable,
    output logic [7:0] data_out,
    output logic       data_valid,
    input  logic       data_ready,
    output logic       frame_start,
    output logic       line_active,
    output logic       overflow,
    output logic [7:0] xy_errors
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int SW = (SKIP_Y > 0) ? $clog2(SKIP_Y + 1) : 1;

    typedef enum logic [1:0] {SEEK, BLANK, ACTIVE} state_t;
    state_t state, state_nx;

    logic [7:0]    h0, h1, h2;
    logic          is_code, prot_ok, accept, sav_start, xy_f, xy_v, xy_h;
    logic          last_v, y_take, y_bit, push_q;
    logic [1:0]    phase;
    logic [SW-1:0] skip_cnt;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg, push_data;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic          full, pop, do_push;

    assign xy_f    = TD_DATA[6];
    assign xy_v    = TD_DATA[5];
    assign xy_h    = TD_DATA[4];
    assign is_code = (h2 == 8'hFF) && (h1 == 8'h00) && (h0 == 8'h00);
`ifdef VIDEO_DATA_DECODER_PROT_CHECK_EN
    assign prot_ok = TD_DATA[7] &&
                     (TD_DATA[3:0] == {xy_v ^ xy_h, xy_f ^ xy_h, xy_f ^ xy_v, xy_f ^ xy_v ^ xy_h});
`else
    assign prot_ok = 1'b1;
`endif
    assign accept    = is_code && prot_ok && enable;
    assign sav_start = accept && !xy_h && !xy_v;
    // An FF in an active line is always the next EAV preamble and is never a sample.
    assign y_take    = enable && (state == ACTIVE) && (TD_DATA != 8'hFF) && phase[0];
    assign y_bit     = (TD_DATA >= THRESHOLD);

    always_comb begin
        state_nx = state;
        if (!enable) begin
            state_nx = SEEK;
        end else begin
            case (state)
                SEEK:    if (accept && xy_h) state_nx = BLANK;
                BLANK:   if (sav_start) state_nx = ACTIVE;
                ACTIVE: begin
                    if (TD_DATA == 8'hFF)            state_nx = BLANK;
                    else if (accept && (xy_h || xy_v)) state_nx = BLANK;
                end
                default: state_nx = SEEK;
            endcase
        end
    end

    always_ff @(posedge TD_CLK27 or negedge rst) begin
        if (!rst) begin
            state       <= SEEK;
            h0          <= 8'h00;
            h1          <= 8'h00;
            h2          <= 8'h00;
            line_active <= 1'b0;
            frame_start <= 1'b0;
            last_v      <= 1'b0;
            phase       <= 2'd0;
            skip_cnt    <= '0;
            bit_cnt     <= 3'd0;
            shreg       <= 8'h00;
            push_q      <= 1'b0;
            push_data   <= 8'h00;
        end else begin
            state       <= state_nx;
            h0          <= TD_DATA;
            h1          <= h0;
            h2          <= h1;
            line_active <= (state == ACTIVE);
            frame_start <= sav_start && last_v;
            push_q      <= 1'b0;
            if (accept) last_v <= xy_v;
            if (!enable) begin
                bit_cnt <= 3'd0;
                shreg   <= 8'h00;
            end else if (sav_start) begin
                phase    <= 2'd0;
                skip_cnt <= '0;
                bit_cnt  <= 3'd0;
                shreg    <= 8'h00;
            end else if (state == ACTIVE) begin
                phase <= phase + 2'd1;
                if (y_take) begin
                    if (skip_cnt < SW'(SKIP_Y)) begin
                        skip_cnt <= skip_cnt + SW'(1);
                    end else begin
                        shreg   <= {shreg[6:0], y_bit};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            push_q    <= 1'b1;
                            push_data <= {shreg[6:0], y_bit};
                        end
                    end
                end
            end
        end
    end

`ifdef VIDEO_DATA_DECODER_PROT_CHECK_EN
    always_ff @(posedge TD_CLK27 or negedge rst) begin
        if (!rst) begin
            xy_errors <= 8'h00;
        end else if (is_code && !prot_ok && (xy_errors != 8'hFF)) begin
            xy_errors <= xy_errors + 8'd1;
        end
    end
`else
    assign xy_errors = 8'h00;
`endif

    // FIFO: extra pointer bit distinguishes full from empty; a pop frees room for a same-cycle push.
    assign data_valid = (wr_ptr != rd_ptr);
    assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop        = data_valid && data_ready;
    assign do_push    = push_q && (!full || pop);
    assign data_out   = data_valid ? mem[rd_ptr[AW-1:0]] : 8'h00;

    always_ff @(posedge TD_CLK27) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

    always_ff @(posedge TD_CLK27 or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)     rd_ptr <= rd_ptr + (AW+1)'(1);
            if (push_q && full && !pop) overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_video_data_decoder.sv
// tb/tb_video_data_decoder.sv - directed table-driven bench for video_data_decoder
module tb_video_data_decoder;
    logic       TD_CLK27 = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] TD_DATA = 8'h00;
    logic       enable = 1'b1;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ready = 1'b1;
    logic       frame_start;
    logic       line_active;
    logic       overflow;
    logic [7:0] xy_errors;

    int         total = 0;
    int         bad = 0;
    int         fs_cnt = 0;
    logic [7:0] cap[$];

    video_data_decoder dut (
        .TD_CLK27(TD_CLK27), .rst(rst), .TD_DATA(TD_DATA), .enable(enable),
        .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
        .frame_start(frame_start), .line_active(line_active), .overflow(overflow),
        .xy_errors(xy_errors)
    );

    always #5 TD_CLK27 = ~TD_CLK27;

    always @(negedge TD_CLK27) begin
        if (data_valid && data_ready) cap.push_back(data_out);
        if (frame_start) fs_cnt++;
    end

    typedef struct {
        logic [7:0] pat;
        logic [7:0] step;
        int         ndata;
        int         exp_n;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        TD_DATA = b;
        @(posedge TD_CLK27);
        #1;
    endtask

    task automatic send_code(input logic [7:0] xy);
        send(8'hFF); send(8'h00); send(8'h00); send(xy);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send(8'h10);
    endtask

    // EAV, blanking, SAV, then 8 skipped Y plus ndata bits; byte k of the line is pat + k*step.
    task automatic send_line(input logic [7:0] sav, input logic [7:0] pat,
                             input logic [7:0] step, input int ndata);
        logic [7:0] bv;
        int bi;
        send_code(8'h9D);
        idle(4);
        send_code(sav);
        for (int i = 0; i < 8 + ndata; i++) begin
            send(8'h80);
            if (i < 8) begin
                send(8'hEB);
            end else begin
                bi = i - 8;
                bv = pat + 8'(int'(step) * (bi / 8));
                send(bv[7 - (bi % 8)] ? 8'hEB : 8'h10);
            end
        end
    endtask

    task automatic send_end();
        send_code(8'h9D);
        idle(8);
    endtask

    function automatic int count_bad(input logic [7:0] pat, input logic [7:0] step, input int n);
        int errs = 0;
        logic [7:0] e;
        for (int k = 0; k < n && k < cap.size(); k++) begin
            e = pat + 8'(int'(step) * k);
            if (cap[k] != e) errs++;
        end
        return errs;
    endfunction

    initial begin
        vec_t vt[5];
        vt[0] = '{8'hA5, 8'd0, 712, 89};
        vt[1] = '{8'h3C, 8'd0, 12, 1};
        vt[2] = '{8'hC3, 8'd0, 16, 2};
        vt[3] = '{8'h5A, 8'd0, 7, 0};
        vt[4] = '{8'h01, 8'd3, 24, 3};

        repeat (3) @(posedge TD_CLK27);
        #1;
        @(negedge TD_CLK27);
        chk("reset_outputs", int'({data_out, data_valid, frame_start, line_active, overflow, xy_errors}), 0);
        rst = 1'b1;
        idle(4);

        for (int r = 0; r < 5; r++) begin
            cap.delete();
            send_line(8'h80, vt[r].pat, vt[r].step, vt[r].ndata);
            send_end();
            chk($sformatf("row%0d_count", r), cap.size(), vt[r].exp_n);
            chk($sformatf("row%0d_bytes", r), count_bad(vt[r].pat, vt[r].step, vt[r].exp_n), 0);
        end
        chk("no_overflow", int'(overflow), 0);

        // Latency: 8th data Y in cycle N shows on data_valid in cycle N+2
        cap.delete();
        send_code(8'h9D);
        idle(2);
        send_code(8'h80);
        for (int i = 0; i < 16; i++) begin
            send(8'h80);
            if (i < 8) send(8'h10);
            else begin
                logic [7:0] p;
                p = 8'hB4;
                send(p[15 - i] ? 8'hEB : 8'h10);
            end
        end
        @(negedge TD_CLK27);
        chk("latency_n1_valid", int'(data_valid), 0);
        send(8'h80);
        @(negedge TD_CLK27);
        chk("latency_n2_valid", int'(data_valid), 1);
        chk("latency_n2_data", int'(data_out), 'hB4);
        send_end();

        // enable=0 drops to SEEK; decoding stays off until the next EAV/SAV
        cap.delete();
        send_code(8'h9D);
        idle(2);
        send_code(8'h80);
        for (int i = 0; i < 6; i++) send(8'h80);
        @(negedge TD_CLK27);
        chk("enable_active", int'(line_active), 1);
        enable = 1'b0;
        send(8'h80);
        send(8'hEB);
        @(negedge TD_CLK27);
        chk("enable_off_inactive", int'(line_active), 0);
        enable = 1'b1;
        for (int i = 0; i < 32; i++) begin send(8'h80); send(8'hEB); end
        idle(4);
        chk("enable_off_no_bytes", cap.size(), 0);

        // frame_start: one pulse after the first V=0 SAV following V=1 codes
        fs_cnt = 0;
        send_code(8'h9D);
        idle(4);
        for (int i = 0; i < 3; i++) begin send_code(8'hAB); idle(6); end
        send_code(8'h80);
        @(negedge TD_CLK27);
        chk("frame_start_pulse", int'(frame_start), 1);
        for (int i = 0; i < 6; i++) send(8'h80);
        send_code(8'h80);
        @(negedge TD_CLK27);
        chk("frame_start_second_sav", int'(frame_start), 0);
        send_end();
        chk("frame_start_count", fs_cnt, 1);

        // Overflow with ready held low, then ordered drain of the first 16
        cap.delete();
        data_ready = 1'b0;
        send_line(8'h80, 8'h01, 8'd1, 712);
        send_line(8'h80, 8'h01, 8'd1, 712);
        send_end();
        @(negedge TD_CLK27);
        chk("ovf_valid", int'(data_valid), 1);
        chk("ovf_flag", int'(overflow), 1);
        chk("ovf_head_stable", int'(data_out), 1);
        data_ready = 1'b1;
        idle(24);
        chk("drain_count", cap.size(), 16);
        chk("drain_order", count_bad(8'h01, 8'd1, 16), 0);

        // Asynchronous reset mid-byte
        cap.delete();
        send_code(8'h9D);
        idle(2);
        send_code(8'h80);
        for (int i = 0; i < 12; i++) begin send(8'h80); send(8'hEB); end
        #2;
        rst = 1'b0;
        #1;
        chk("async_reset_outputs", int'({data_out, data_valid, frame_start, line_active, overflow, xy_errors}), 0);
        @(posedge TD_CLK27);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 16; i++) begin send(8'h80); send(8'hEB); end
        send_code(8'h80);
        for (int i = 0; i < 24; i++) begin send(8'h80); send(8'hEB); end
        idle(4);
        chk("post_reset_no_bytes", cap.size(), 0);
        send_line(8'h80, 8'h77, 8'd0, 8);
        send_end();
        chk("post_reset_relock", cap.size(), 1);
        chk("post_reset_byte", count_bad(8'h77, 8'd0, 1), 0);

`ifdef VIDEO_DATA_DECODER_PROT_CHECK_EN
        cap.delete();
        send_line(8'h81, 8'h0F, 8'd0, 16);
        send_end();
        chk("prot_bad_no_bytes", cap.size(), 0);
        chk("prot_xy_errors", int'(xy_errors), 1);
        send_line(8'h80, 8'h0F, 8'd0, 16);
        send_end();
        chk("prot_resume_count", cap.size(), 2);
`else
        chk("xy_errors_tied", int'(xy_errors), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
